ysyx_23060124_wbu_commit: RTL and testbench
===========================================

Name: ysyx_23060124_wbu_commit

Overview:
- Write-back/commit stage at the consumer end of the EXU->WBU pipeline register.
- Accepts one retiring instruction per valid/ready handshake and drives the GPR write port, the CSR write port, PC redirect to IFU, and the halt flag.
- Sequences the two-cycle ecall trap (mepc, then mcause) and maintains a retired-instruction counter.

Parameters:
- XLEN, 32, data/PC width
- RF_AW, 4, GPR address width (16-entry RV32E file)
- MEPC_ADDR, 12'h341, CSR address written first on ecall
- MCAUSE_ADDR, 12'h342, CSR address written second on ecall
- ECALL_CAUSE, 11, mcause value for ecall from M-mode

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- i_valid  in  1  EXU->WBU register holds a valid instruction
- o_ready  out  1  WBU can accept this cycle
- i_res  in  XLEN  rd write data; on ecall, faulting PC (mepc value)
- i_csr_wdata  in  XLEN  CSR write data
- i_pc_next  in  XLEN  resolved next PC (branch/jump target, mret target, mtvec on ecall)
- i_rd_addr  in  RF_AW  destination GPR
- i_csr_addr  in  12  destination CSR
- i_wen, i_csr_wen  in  1 each  GPR / CSR write enables
- i_brch, i_jal, i_jalr, i_mret, i_ecall, i_ebreak  in  1 each  instruction class flags
- o_rf_wen  out  1  GPR write strobe
- o_rf_waddr  out  RF_AW  GPR write address
- o_rf_wdata  out  XLEN  GPR write data
- o_csr_wen  out  1  CSR write strobe
- o_csr_waddr  out  12  CSR write address
- o_csr_wdata  out  XLEN  CSR write data
- o_redirect  out  1  one-cycle PC redirect pulse to IFU
- o_redirect_pc  out  XLEN  redirect target
- o_halt  out  1  sticky, set by ebreak
- o_retire_cnt  out  32  retired-instruction count

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE; every output 0 except o_ready=1. Reset mid-trap abandons the mcause write. Reset also clears o_halt.
- Accept = i_valid && o_ready.
- o_ready = 1 only in IDLE. It is 0 in TRAP_MCAUSE and HALT.
- All outputs are registered. Effects of an accepted instruction appear in the cycle after acceptance (latency 1).
- Strobes (o_rf_wen, o_csr_wen, o_redirect) are one-cycle pulses. They are 0 in every cycle without a corresponding commit action. Address/data outputs hold their last value when strobes are low.
- IDLE, accept, plain instruction (no ecall/ebreak):
  - o_rf_wen = i_wen && (i_rd_addr != 0), with waddr = i_rd_addr and wdata = i_res.
  - o_csr_wen = i_csr_wen, with waddr = i_csr_addr and wdata = i_csr_wdata. GPR and CSR writes may both fire in the same cycle (csrrw).
  - o_redirect = i_brch | i_jal | i_jalr | i_mret, with o_redirect_pc = i_pc_next.
  - o_retire_cnt increments by 1.
- IDLE, accept, i_ecall:
  - Next cycle: o_csr_wen=1, waddr=MEPC_ADDR, wdata=i_res. i_pc_next is latched internally. State becomes TRAP_MCAUSE.
  - GPR write is suppressed regardless of i_wen.
- TRAP_MCAUSE:
  - Next cycle: o_csr_wen=1, waddr=MCAUSE_ADDR, wdata=ECALL_CAUSE.
  - o_redirect=1 with o_redirect_pc = latched pc_next.
  - o_retire_cnt increments. State returns to IDLE.
- IDLE, accept, i_ebreak:
  - Next cycle: o_halt=1, and the instruction retires (count +1). No GPR, CSR, or redirect side effects.
  - State becomes HALT. HALT is left only by reset.
- Flag priority when several flags are set: ebreak > ecall > others.
- o_retire_cnt wraps from 32'hFFFF_FFFF to 0.
- i_valid while o_ready==0: the input is not consumed and must be held by the producer.

Test Plan:
- Reset low for 2 cycles, then high -> all strobes 0, o_ready=1, o_retire_cnt=0, o_halt=0.
- Accept i_wen=1, rd=5, res=32'hDEAD_BEEF -> next cycle rf_wen=1, waddr=5, wdata=DEADBEEF, count=1. Repeat with rd=0 -> rf_wen stays 0, count=2.
- Accept i_jal=1, i_wen=1, rd=1, res=32'h8000_0008, pc_next=32'h8000_0100 -> same cycle rf_wen=1 and redirect=1 with pc 80000100.
- Accept i_ecall=1, res=32'h8000_0040, pc_next=32'h8000_0200, with i_valid held high -> cycle+1: csr write 0x341=80000040, ready=0. Cycle+2: csr write 0x342=11, redirect to 80000200, count +1. Cycle+3: ready=1.
- Accept ebreak -> o_halt=1 and o_ready=0 forever, further i_valid ignored. Reset low -> halt cleared.
- Preload count to 32'hFFFF_FFFF via back-to-back commits (or force), commit once -> count=0. Assert reset during TRAP_MCAUSE -> no mcause write, IDLE.

Source files
------------

// File: rtl/ysyx_23060124_wbu_commit.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060124_wbu_commit
// Description : Write-back / commit stage. Retires one instruction per
//               valid/ready handshake, drives GPR and CSR write ports, issues
//               PC redirects, sequences the two-cycle ecall trap (mepc, then
//               mcause), latches the ebreak halt flag and counts retirements.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060124_wbu_commit #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned RF_AW       = 4,
    parameter logic [11:0] MEPC_ADDR   = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR = 12'h342,
    parameter int unsigned ECALL_CAUSE = 11
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [XLEN-1:0]  i_res,
    input  logic [XLEN-1:0]  i_csr_wdata,
    input  logic [XLEN-1:0]  i_pc_next,
    input  logic [RF_AW-1:0] i_rd_addr,
    input  logic [11:0]      i_csr_addr,
    input  logic             i_wen,
    input  logic             i_csr_wen,
    input  logic             i_brch,
    input  logic             i_jal,
    input  logic             i_jalr,
    input  logic             i_mret,
    input  logic             i_ecall,
    input  logic             i_ebreak,
    output logic             o_rf_wen,
    output logic [RF_AW-1:0] o_rf_waddr,
    output logic [XLEN-1:0]  o_rf_wdata,
    output logic             o_csr_wen,
    output logic [11:0]      o_csr_waddr,
    output logic [XLEN-1:0]  o_csr_wdata,
    output logic             o_redirect,
    output logic [XLEN-1:0]  o_redirect_pc,
    output logic             o_halt,
    output logic [31:0]      o_retire_cnt
);

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_TRAP_MCAUSE = 2'd1,
        S_HALT        = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic               r_rf_wen,      w_rf_wen;
    logic [RF_AW-1:0]   r_rf_waddr,    w_rf_waddr;
    logic [XLEN-1:0]    r_rf_wdata,    w_rf_wdata;
    logic               r_csr_wen,     w_csr_wen;
    logic [11:0]        r_csr_waddr,   w_csr_waddr;
    logic [XLEN-1:0]    r_csr_wdata,   w_csr_wdata;
    logic               r_redirect,    w_redirect;
    logic [XLEN-1:0]    r_redirect_pc, w_redirect_pc;
    logic               r_halt,        w_halt;
    logic [XLEN-1:0]    r_trap_pc,     w_trap_pc;
    logic [31:0]        r_retire_cnt;
    logic               w_retire;
    logic               w_accept;

    // Only an idle stage can take a new instruction; trap sequencing and halt stall the producer.
    assign o_ready       = (r_state == S_IDLE);
    assign w_accept      = i_valid && (r_state == S_IDLE);

    assign o_rf_wen      = r_rf_wen;
    assign o_rf_waddr    = r_rf_waddr;
    assign o_rf_wdata    = r_rf_wdata;
    assign o_csr_wen     = r_csr_wen;
    assign o_csr_waddr   = r_csr_waddr;
    assign o_csr_wdata   = r_csr_wdata;
    assign o_redirect    = r_redirect;
    assign o_redirect_pc = r_redirect_pc;
    assign o_halt        = r_halt;
    assign o_retire_cnt  = r_retire_cnt;

    // Next-state and next-output decode; strobes default low, address/data hold.
    always_comb begin
        w_state_next  = r_state;
        w_rf_wen      = 1'b0;
        w_rf_waddr    = r_rf_waddr;
        w_rf_wdata    = r_rf_wdata;
        w_csr_wen     = 1'b0;
        w_csr_waddr   = r_csr_waddr;
        w_csr_wdata   = r_csr_wdata;
        w_redirect    = 1'b0;
        w_redirect_pc = r_redirect_pc;
        w_halt        = r_halt;
        w_trap_pc     = r_trap_pc;
        w_retire      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (i_ebreak) begin
                        // ebreak wins over every other flag and retires with no side effects
                        w_halt       = 1'b1;
                        w_retire     = 1'b1;
                        w_state_next = S_HALT;
                    end else if (i_ecall) begin
                        // First trap beat: mepc <= faulting PC carried on i_res
                        w_csr_wen    = 1'b1;
                        w_csr_waddr  = MEPC_ADDR;
                        w_csr_wdata  = i_res;
                        w_trap_pc    = i_pc_next;
                        w_state_next = S_TRAP_MCAUSE;
                    end else begin
                        // x0 is never written
                        if (i_wen && (i_rd_addr != '0)) begin
                            w_rf_wen   = 1'b1;
                            w_rf_waddr = i_rd_addr;
                            w_rf_wdata = i_res;
                        end
                        if (i_csr_wen) begin
                            w_csr_wen   = 1'b1;
                            w_csr_waddr = i_csr_addr;
                            w_csr_wdata = i_csr_wdata;
                        end
                        if (i_brch || i_jal || i_jalr || i_mret) begin
                            w_redirect    = 1'b1;
                            w_redirect_pc = i_pc_next;
                        end
                        w_retire = 1'b1;
                    end
                end
            end
            S_TRAP_MCAUSE: begin
                // Second trap beat: mcause write, jump to the latched handler, retire the ecall
                w_csr_wen     = 1'b1;
                w_csr_waddr   = MCAUSE_ADDR;
                w_csr_wdata   = XLEN'(ECALL_CAUSE);
                w_redirect    = 1'b1;
                w_redirect_pc = r_trap_pc;
                w_retire      = 1'b1;
                w_state_next  = S_IDLE;
            end
            S_HALT: begin
                w_state_next = S_HALT;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State, output and counter registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_rf_wen      <= 1'b0;
            r_rf_waddr    <= '0;
            r_rf_wdata    <= '0;
            r_csr_wen     <= 1'b0;
            r_csr_waddr   <= '0;
            r_csr_wdata   <= '0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_halt        <= 1'b0;
            r_trap_pc     <= '0;
            r_retire_cnt  <= '0;
        end else begin
            r_state       <= w_state_next;
            r_rf_wen      <= w_rf_wen;
            r_rf_waddr    <= w_rf_waddr;
            r_rf_wdata    <= w_rf_wdata;
            r_csr_wen     <= w_csr_wen;
            r_csr_waddr   <= w_csr_waddr;
            r_csr_wdata   <= w_csr_wdata;
            r_redirect    <= w_redirect;
            r_redirect_pc <= w_redirect_pc;
            r_halt        <= w_halt;
            r_trap_pc     <= w_trap_pc;
            if (w_retire) begin
                r_retire_cnt <= r_retire_cnt + 32'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060124_wbu_commit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_23060124_wbu_commit
// Description : Self-checking bench for the write-back/commit stage. Directed
//               scenarios followed by random traffic, all outputs compared
//               every cycle against a behavioural commit model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060124_wbu_commit;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid;
    logic        ready;
    logic [31:0] res, csr_wdata, pc_next;
    logic [3:0]  rd_addr;
    logic [11:0] csr_addr;
    logic        wen, csr_wen, brch, jal, jalr, mret, ecall, ebreak;
    logic        rf_wen, csr_wen_o, redirect, halt;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata, csr_wdata_o, redirect_pc, retire_cnt;
    logic [11:0] csr_waddr;

    int checks = 0;
    int errors = 0;

    // Reference model: what the outputs must look like after the next edge.
    bit          m_halted, m_trap_pending;
    logic [31:0] m_trap_pc;
    logic        e_ready, e_rf_wen, e_csr_wen, e_redirect, e_halt;
    logic [3:0]  e_rf_waddr;
    logic [11:0] e_csr_waddr;
    logic [31:0] e_rf_wdata, e_csr_wdata, e_redirect_pc, e_cnt;

    ysyx_23060124_wbu_commit dut (
        .clock        (clock),
        .reset        (reset),
        .i_valid      (valid),
        .o_ready      (ready),
        .i_res        (res),
        .i_csr_wdata  (csr_wdata),
        .i_pc_next    (pc_next),
        .i_rd_addr    (rd_addr),
        .i_csr_addr   (csr_addr),
        .i_wen        (wen),
        .i_csr_wen    (csr_wen),
        .i_brch       (brch),
        .i_jal        (jal),
        .i_jalr       (jalr),
        .i_mret       (mret),
        .i_ecall      (ecall),
        .i_ebreak     (ebreak),
        .o_rf_wen     (rf_wen),
        .o_rf_waddr   (rf_waddr),
        .o_rf_wdata   (rf_wdata),
        .o_csr_wen    (csr_wen_o),
        .o_csr_waddr  (csr_waddr),
        .o_csr_wdata  (csr_wdata_o),
        .o_redirect   (redirect),
        .o_redirect_pc(redirect_pc),
        .o_halt       (halt),
        .o_retire_cnt (retire_cnt)
    );

    // 10 ns clock
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        valid = 0; res = 0; csr_wdata = 0; pc_next = 0; rd_addr = 0; csr_addr = 0;
        wen = 0; csr_wen = 0; brch = 0; jal = 0; jalr = 0; mret = 0; ecall = 0; ebreak = 0;
    endtask

    // Apply the commit rules to the inputs presented this cycle.
    task automatic model_step();
        e_rf_wen   = 0;
        e_csr_wen  = 0;
        e_redirect = 0;
        if (!reset) begin
            m_halted = 0; m_trap_pending = 0; m_trap_pc = 0;
            e_rf_waddr = 0; e_rf_wdata = 0; e_csr_waddr = 0; e_csr_wdata = 0;
            e_redirect_pc = 0; e_cnt = 0;
        end else if (m_trap_pending) begin
            e_csr_wen = 1; e_csr_waddr = 12'h342; e_csr_wdata = 32'd11;
            e_redirect = 1; e_redirect_pc = m_trap_pc;
            e_cnt = e_cnt + 1;
            m_trap_pending = 0;
        end else if (!m_halted && valid) begin
            if (ebreak) begin
                m_halted = 1;
                e_cnt = e_cnt + 1;
            end else if (ecall) begin
                e_csr_wen = 1; e_csr_waddr = 12'h341; e_csr_wdata = res;
                m_trap_pc = pc_next;
                m_trap_pending = 1;
            end else begin
                if (wen && rd_addr != 0) begin
                    e_rf_wen = 1; e_rf_waddr = rd_addr; e_rf_wdata = res;
                end
                if (csr_wen) begin
                    e_csr_wen = 1; e_csr_waddr = csr_addr; e_csr_wdata = csr_wdata;
                end
                if (brch || jal || jalr || mret) begin
                    e_redirect = 1; e_redirect_pc = pc_next;
                end
                e_cnt = e_cnt + 1;
            end
        end
        e_halt  = m_halted;
        e_ready = !m_halted && !m_trap_pending;
    endtask

    task automatic check_all();
        chk("ready",       {31'd0, ready},     {31'd0, e_ready});
        chk("rf_wen",      {31'd0, rf_wen},    {31'd0, e_rf_wen});
        chk("rf_waddr",    {28'd0, rf_waddr},  {28'd0, e_rf_waddr});
        chk("rf_wdata",    rf_wdata,           e_rf_wdata);
        chk("csr_wen",     {31'd0, csr_wen_o}, {31'd0, e_csr_wen});
        chk("csr_waddr",   {20'd0, csr_waddr}, {20'd0, e_csr_waddr});
        chk("csr_wdata",   csr_wdata_o,        e_csr_wdata);
        chk("redirect",    {31'd0, redirect},  {31'd0, e_redirect});
        chk("redirect_pc", redirect_pc,        e_redirect_pc);
        chk("halt",        {31'd0, halt},      {31'd0, e_halt});
        chk("retire_cnt",  retire_cnt,         e_cnt);
    endtask

    // One clock: predict, let the edge happen, compare on the falling edge.
    task automatic tick();
        model_step();
        @(posedge clock);
        @(negedge clock);
        check_all();
    endtask

    task automatic rand_instr();
        valid     = ($urandom_range(0, 3) != 0);
        res       = $urandom;
        csr_wdata = $urandom;
        pc_next   = $urandom;
        rd_addr   = 4'($urandom_range(0, 15));
        csr_addr  = 12'($urandom_range(0, 4095));
        wen       = 1'($urandom_range(0, 1));
        csr_wen   = ($urandom_range(0, 2) == 0);
        brch      = ($urandom_range(0, 3) == 0);
        jal       = ($urandom_range(0, 5) == 0);
        jalr      = ($urandom_range(0, 5) == 0);
        mret      = ($urandom_range(0, 9) == 0);
        ecall     = ($urandom_range(0, 7) == 0);
        ebreak    = ($urandom_range(0, 39) == 0);
    endtask

    initial begin
        clear_inputs();
        m_halted = 0; m_trap_pending = 0; m_trap_pc = 0; e_cnt = 0;
        reset = 0;
        @(negedge clock);

        // Reset held for two cycles
        tick();
        tick();
        reset = 1;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_cnt", retire_cnt, 32'd0);
        chk("rst_halt", {31'd0, halt}, 32'd0);

        // Plain GPR write, then the same write to x0
        valid = 1; wen = 1; rd_addr = 4'd5; res = 32'hDEAD_BEEF;
        tick();
        chk("gpr_wdata", rf_wdata, 32'hDEAD_BEEF);
        chk("gpr_cnt1", retire_cnt, 32'd1);
        rd_addr = 4'd0;
        tick();
        chk("x0_wen", {31'd0, rf_wen}, 32'd0);
        chk("x0_cnt2", retire_cnt, 32'd2);

        // jal: link write and redirect in the same cycle
        clear_inputs();
        valid = 1; jal = 1; wen = 1; rd_addr = 4'd1; res = 32'h8000_0008; pc_next = 32'h8000_0100;
        tick();
        chk("jal_rfwen", {31'd0, rf_wen}, 32'd1);
        chk("jal_redir_pc", redirect_pc, 32'h8000_0100);

        // ecall with i_valid held through the trap beat
        clear_inputs();
        valid = 1; ecall = 1; wen = 1; rd_addr = 4'd3; res = 32'h8000_0040; pc_next = 32'h8000_0200;
        tick();
        chk("ecall_mepc", csr_wdata_o, 32'h8000_0040);
        chk("ecall_ready0", {31'd0, ready}, 32'd0);
        tick();
        chk("ecall_mcause_addr", {20'd0, csr_waddr}, 32'h342);
        chk("ecall_mcause", csr_wdata_o, 32'd11);
        chk("ecall_redir", redirect_pc, 32'h8000_0200);
        chk("ecall_cnt", retire_cnt, 32'd4);
        clear_inputs();
        tick();

        // ebreak: halt, further traffic ignored, reset clears it
        valid = 1; ebreak = 1; ecall = 1; wen = 1; rd_addr = 4'd7;
        tick();
        chk("ebreak_halt", {31'd0, halt}, 32'd1);
        chk("ebreak_cnt", retire_cnt, 32'd5);
        ebreak = 0; ecall = 0; csr_wen = 1; jal = 1;
        for (int i = 0; i < 4; i++) tick();
        chk("halt_ready", {31'd0, ready}, 32'd0);
        clear_inputs();
        reset = 0;
        tick();
        reset = 1;
        chk("halt_cleared", {31'd0, halt}, 32'd0);

        // Counter wrap: preload the counter, then one commit
        force dut.r_retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_retire_cnt;
        e_cnt = 32'hFFFF_FFFF;
        valid = 1; wen = 1; rd_addr = 4'd2; res = 32'h1234_5678;
        tick();
        chk("cnt_wrap", retire_cnt, 32'd0);

        // Reset in the middle of the trap sequence drops the mcause write
        clear_inputs();
        valid = 1; ecall = 1; res = 32'h0000_0100; pc_next = 32'h0000_0800;
        tick();
        clear_inputs();
        reset = 0;
        tick();
        reset = 1;
        chk("midtrap_csr_wen", {31'd0, csr_wen_o}, 32'd0);
        chk("midtrap_ready", {31'd0, ready}, 32'd1);
        tick();
        chk("midtrap_redirect", {31'd0, redirect}, 32'd0);

        // Random traffic, occasional resets, recovery from halts
        for (int i = 0; i < 600; i++) begin
            rand_instr();
            reset = !(($urandom_range(0, 99) == 0) || (m_halted && $urandom_range(0, 3) == 0));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
